// File: rtl/mem_access_unit.sv
// Sequencer between the CPU load/store port and a registered-read data memory.
// Each request gets one memory cycle; byte and halfword load results are extended.
//
// state | meaning
// IDLE  | waiting for req; latches the access when req is sampled
// ISSUE | one-cycle memory strobe (m_sel with m_ld or m_str)
// RESP  | memory read data valid; rdata is registered at the end of this cycle
// DONE  | done pulse, with err if the access faulted
module mem_access_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  req,
  input  logic                  wr,
  input  logic [1:0]            size,
  input  logic                  sext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_din,
  output logic [1:0]            m_mode,
  output logic                  m_str,
  output logic                  m_ld,
  output logic                  m_sel,
  input  logic [31:0]           m_dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  state_t                state_q, state_d;
  logic                  wr_q, sext_q, fault_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q, load_ext;
  logic                  fault_in;

  // Misaligned halfword/word or reserved size: completes without touching memory.
  assign fault_in = (size == 2'b11) ||
                    ((size == 2'b01) && addr[0]) ||
                    ((size == 2'b10) && (addr[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (clr) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = fault_in ? DONE : ISSUE;
      ISSUE:   state_d = wr_q ? DONE : RESP;
      RESP:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ext = m_dout;
    case (size_q)
      2'b00:   load_ext = {{24{sext_q & m_dout[7]}},  m_dout[7:0]};
      2'b01:   load_ext = {{16{sext_q & m_dout[15]}}, m_dout[15:0]};
      default: load_ext = m_dout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (state_q == IDLE && req) begin
        wr_q    <= wr;
        sext_q  <= sext;
        fault_q <= fault_in;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_q == RESP) rdata_q <= load_ext;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign err    = (state_q == DONE) && fault_q;
  assign rdata  = rdata_q;
  assign m_sel  = (state_q == ISSUE);
  assign m_ld   = (state_q == ISSUE) && !wr_q;
  assign m_str  = (state_q == ISSUE) && wr_q;
  assign m_addr = addr_q;
  assign m_din  = wdata_q;
  assign m_mode = size_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random load/store traffic against a registered-read memory model,
// checked against a byte-array reference of memory contents and the load result.
module tb_mem_access_unit;

  logic        clk, clr, req, wr, sext;
  logic [1:0]  size;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [11:0] m_addr;
  logic [31:0] m_din;
  logic [1:0]  m_mode;
  logic        m_str, m_ld, m_sel;
  logic [31:0] m_dout;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ref_mem [4096];
  logic [31:0] ref_rdata;

  mem_access_unit #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .clr(clr), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .m_addr(m_addr), .m_din(m_din), .m_mode(m_mode),
    .m_str(m_str), .m_ld(m_ld), .m_sel(m_sel), .m_dout(m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  // Data memory: word array, right-aligned registered read, lane-placed write.
  logic [31:0] mem [1024];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (m_sel) begin
      if (m_ld) begin
        case (m_mode)
          2'b00:   m_dout <= mem[m_addr[11:2]] >> (8 * m_addr[1:0]);
          2'b01:   m_dout <= mem[m_addr[11:2]] >> (16 * m_addr[1]);
          default: m_dout <= mem[m_addr[11:2]];
        endcase
      end
      if (m_str) begin
        case (m_mode)
          2'b00:   mem[m_addr[11:2]][8*m_addr[1:0] +: 8]   <= m_din[7:0];
          2'b01:   mem[m_addr[11:2]][16*m_addr[1] +: 16]   <= m_din[15:0];
          default: mem[m_addr[11:2]]                       <= m_din;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(logic [1:0] sz, logic sx, logic [11:0] a);
    logic [31:0] v;
    int ai;
    ai = int'(a);
    case (sz)
      2'b00: begin
        v = {24'h0, ref_mem[ai]};
        if (sx && v[7]) v = v | 32'hFFFFFF00;
      end
      2'b01: begin
        v = {16'h0, ref_mem[ai+1], ref_mem[ai]};
        if (sx && v[15]) v = v | 32'hFFFF0000;
      end
      default: v = {ref_mem[ai+3], ref_mem[ai+2], ref_mem[ai+1], ref_mem[ai]};
    endcase
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after done.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [11:0] a, input logic [31:0] wd);
    bit   fault;
    int   exp_lat, done_cyc, sel_cnt;
    logic [31:0] exp_rd;
    fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_lat = fault ? 1 : (w ? 2 : 3);
    exp_rd  = (!fault && !w) ? ref_load(sz, sx, a) : ref_rdata;
    wr = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    done_cyc = 0;
    sel_cnt  = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (c == 1) check("busy_c1", {31'h0, busy}, 32'h1);
      if (m_sel) begin
        sel_cnt++;
        check("m_addr", {20'h0, m_addr}, {20'h0, a});
        check("m_mode", {30'h0, m_mode}, {30'h0, sz});
        check("m_ld", {31'h0, m_ld}, {31'h0, ~w});
        check("m_str", {31'h0, m_str}, {31'h0, w});
        check("m_din", m_din, wd);
      end else begin
        check("strobes_idle", {29'h0, m_sel, m_ld, m_str}, 32'h0);
      end
      if (done_cyc != 0) begin
        check("done_pulse", {30'h0, done, err}, 32'h0);
        check("busy_after", {31'h0, busy}, 32'h0);
        break;
      end
      if (done) begin
        done_cyc = c;
        check("err", {31'h0, err}, {31'h0, fault});
        check("rdata", rdata, exp_rd);
        check("m_addr_hold", {20'h0, m_addr}, {20'h0, a});
      end
    end
    check("latency", done_cyc, exp_lat);
    check("sel_count", sel_cnt, fault ? 0 : 1);
    if (!fault) begin
      if (w) begin
        case (sz)
          2'b00: ref_mem[int'(a)] = wd[7:0];
          2'b01: begin ref_mem[int'(a)] = wd[7:0]; ref_mem[int'(a)+1] = wd[15:8]; end
          default: for (int b = 0; b < 4; b++) ref_mem[int'(a)+b] = wd[8*b +: 8];
        endcase
      end else begin
        ref_rdata = exp_rd;
      end
    end
  endtask

  initial begin
    logic [31:0] w32;
    for (int i = 0; i < 1024; i++) begin
      w32 = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[i*4+b] = w32[8*b +: 8];
    end
    ref_rdata = 32'h0;
    clr = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 12'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_flags", {26'h0, busy, done, err, m_sel, m_ld, m_str}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_maddr", {20'h0, m_addr}, 32'h0);
    check("rst_mdin", m_din, 32'h0);
    check("rst_mmode", {30'h0, m_mode}, 32'h0);
    clr = 1'b0;
    @(negedge clk);

    do_access(1'b0, 2'b00, 1'b1, 12'h013, 32'h0);
    check("byte_sext", rdata, 32'hFFFFFF88);
    do_access(1'b0, 2'b01, 1'b0, 12'h012, 32'h0);
    check("half_zext", rdata, 32'h00008899);
    do_access(1'b0, 2'b01, 1'b1, 12'h012, 32'h0);
    check("half_sext", rdata, 32'hFFFF8899);
    do_access(1'b1, 2'b10, 1'b0, 12'h020, 32'hDEADBEEF);
    check("store_keeps_rdata", rdata, 32'hFFFF8899);
    do_access(1'b0, 2'b10, 1'b0, 12'h020, 32'h0);
    check("word_after_store", rdata, 32'hDEADBEEF);
    do_access(1'b0, 2'b10, 1'b0, 12'h022, 32'h0);
    do_access(1'b1, 2'b11, 1'b0, 12'h024, 32'h12345678);
    do_access(1'b0, 2'b01, 1'b0, 12'h011, 32'h0);
    check("fault_keeps_rdata", rdata, 32'hDEADBEEF);

    // req held for ten sampled edges: accesses start every fourth cycle
    wr = 1'b0; size = 2'b10; sext = 1'b0; addr = 12'h020; req = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("held_sel", {31'h0, m_sel}, {31'h0, (k == 1 || k == 5 || k == 9)});
      check("held_done", {31'h0, done}, {31'h0, (k == 3 || k == 7 || k == 11)});
      if (k == 10) req = 1'b0;
    end
    check("held_rdata", rdata, 32'hDEADBEEF);

    // clr while in RESP aborts the load
    wr = 1'b0; size = 2'b10; addr = 12'h010; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("abort_issue", {31'h0, m_sel}, 32'h1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_maddr", {20'h0, m_addr}, 32'h0);
    ref_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_done", {31'h0, done}, 32'h0);
    end

    for (int n = 0; n < 150; n++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
